// File: rtl/mem_write_checker.sv
// Data-memory write-port checker: compares processor stores against an
// ordered table of expected (address, data) pairs and reports a verdict.
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int NCHECK  = 4,
    parameter int TIMEOUT = 1000,
    parameter int STRICT  = 1,
    localparam int IW = (NCHECK > 1) ? $clog2(NCHECK) : 1,
    localparam int MW = $clog2(NCHECK + 1),
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             start,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [MW-1:0]    match_count,
    output logic [CW-1:0]    cycle_count,
    output logic [WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0] fail_data
);
    localparam int TSZ = 2 ** IW;
    // With the timeout disabled the counter simply saturates at all-ones.
    localparam logic [CW-1:0] CSAT = (TIMEOUT > 0) ? CW'(TIMEOUT) : {CW{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t           state, state_n;
    logic [MW-1:0]    mc_n, mc_inc;
    logic [CW-1:0]    cyc_n, cyc_inc;
    logic [1:0]       code_n;
    logic [WIDTH-1:0] fa_n, fd_n;
    logic [WIDTH-1:0] exp_addr [TSZ];
    logic [WIDTH-1:0] exp_data [TSZ];
    logic [IW-1:0]    cur_idx;
    logic             verdict;

    // Entries at or above NCHECK are never written, so they stay zero.
    assign cur_idx = IW'(match_count);
    assign mc_inc  = match_count + MW'(1);
    assign cyc_inc = (cycle_count == CSAT) ? cycle_count : cycle_count + CW'(1);

    assign done = (state == S_PASS) || (state == S_FAIL);
    assign pass = (state == S_PASS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            match_count <= '0;
            cycle_count <= '0;
            fail_code   <= 2'd0;
            fail_addr   <= '0;
            fail_data   <= '0;
            for (int i = 0; i < TSZ; i++) begin
                exp_addr[i] <= '0;
                exp_data[i] <= '0;
            end
        end else begin
            state       <= state_n;
            match_count <= mc_n;
            cycle_count <= cyc_n;
            fail_code   <= code_n;
            fail_addr   <= fa_n;
            fail_data   <= fd_n;
            if (state == S_IDLE && cfg_we && int'(cfg_idx) < NCHECK) begin
                exp_addr[cfg_idx] <= cfg_addr;
                exp_data[cfg_idx] <= cfg_data;
            end
        end
    end

    always_comb begin
        state_n = state;
        mc_n    = match_count;
        cyc_n   = cycle_count;
        code_n  = fail_code;
        fa_n    = fail_addr;
        fd_n    = fail_data;
        verdict = 1'b0;
        case (state)
            S_RUN: begin
                cyc_n = cyc_inc;
                if (memwrite && dataadr == exp_addr[cur_idx]) begin
                    if (writedata == exp_data[cur_idx]) begin
                        mc_n = mc_inc;
                        if (int'(mc_inc) == NCHECK) begin
                            state_n = S_PASS;
                            verdict = 1'b1;
                        end
                    end else begin
                        state_n = S_FAIL;
                        code_n  = 2'd2;
                        fa_n    = dataadr;
                        fd_n    = writedata;
                        verdict = 1'b1;
                    end
                end else if (memwrite && STRICT != 0) begin
                    state_n = S_FAIL;
                    code_n  = 2'd1;
                    fa_n    = dataadr;
                    fd_n    = writedata;
                    verdict = 1'b1;
                end
                // A store verdict on the same edge takes precedence over timeout.
                if (!verdict && TIMEOUT != 0 && cyc_inc == CSAT) begin
                    state_n = S_FAIL;
                    code_n  = 2'd3;
                end
            end
            default: begin
                if (start) begin
                    state_n = S_RUN;
                    mc_n    = '0;
                    cyc_n   = '0;
                    code_n  = 2'd0;
                    fa_n    = '0;
                    fd_n    = '0;
                end
            end
        endcase
    end
endmodule
